clk_pll_emu: RTL and testbench



---
 rtl/clk_pll_emu.sv | 190 +++++++++++++++++++
 tb/tb_clk_pll_emu.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/clk_pll_emu.sv
// clk_pll_emu
// Clock-generation emulator. From the single reference clock clk_i it derives
// NumPlls programmable divided clocks (clk_pll_o), half-rate debug copies of
// them (dbg_pll_o), per-channel lock flags (lock_o) and a fixed real-time
// clock (rt_clk_o). Ratio changes use a valid/ready request; a channel only
// switches ratio at the end of a high phase, so no runt pulses are produced.
//
// Ports:
//   clk_i        reference clock
//   rst_i        asynchronous active-high reset
//   cfg_valid_i  ratio-change request valid
//   cfg_ready_o  request accepted when valid && ready (combinational on cfg_idx_i)
//   cfg_idx_i    target channel
//   cfg_div_i    new ratio D (0 parks the channel low)
//   cfg_err_o    one-cycle pulse after an accepted request to a non-existent channel
//   clk_pll_o    divided clocks, period 2*D
//   dbg_pll_o    half-rate copies, period 4*D
//   lock_o       per-channel lock
//   rt_clk_o     fixed real-time clock, period 2*RtDiv
module clk_pll_emu #(
  parameter int NumPlls    = 3,
  parameter int DivWidth   = 8,
  parameter int DefaultDiv = 1,
  parameter int LockCycles = 16,
  parameter int RtDiv      = 16,
  parameter int IdxWidth   = (NumPlls > 1) ? $clog2(NumPlls) : 1
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                cfg_valid_i,
  output logic                cfg_ready_o,
  input  logic [IdxWidth-1:0] cfg_idx_i,
  input  logic [DivWidth-1:0] cfg_div_i,
  output logic                cfg_err_o,
  output logic [NumPlls-1:0]  clk_pll_o,
  output logic [NumPlls-1:0]  dbg_pll_o,
  output logic [NumPlls-1:0]  lock_o,
  output logic                rt_clk_o
);

  localparam int LcntWidth = (LockCycles > 0) ? $clog2(LockCycles + 1) : 1;
  localparam int RtWidth   = (RtDiv > 1) ? $clog2(RtDiv) : 1;
  localparam logic [LcntWidth-1:0] LockLast = LcntWidth'(LockCycles - 1);
  localparam logic [RtWidth-1:0]   RtLast   = RtWidth'(RtDiv - 1);

  typedef enum logic [1:0] {
    ST_LOCKING = 2'd0,
    ST_LOCKED  = 2'd1,
    ST_SWITCH  = 2'd2
  } pll_state_e;

  logic [NumPlls-1:0] sw_s;    // channel is in SWITCH
  logic [NumPlls-1:0] hit_s;   // accepted request targets this channel
  logic               idx_bad_s;
  logic               ready_s;
  logic               err_r;
  logic [RtWidth-1:0] rt_cnt_r;
  logic               rt_r;

  assign idx_bad_s = (32'(cfg_idx_i) >= 32'(NumPlls));

  // Ready is low only while the addressed channel is mid-switch.
  always_comb begin
    ready_s = 1'b1;
    for (int i = 0; i < NumPlls; i++) begin
      ready_s = ready_s & ~((cfg_idx_i == IdxWidth'(i)) & sw_s[i]);
    end
  end

  assign cfg_ready_o = ready_s;

  // Error pulse for an accepted request to a channel that does not exist.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      err_r <= 1'b0;
    end else begin
      err_r <= cfg_valid_i & ready_s & idx_bad_s;
    end
  end

  assign cfg_err_o = err_r;

  // Free-running real-time clock divider, independent of cfg traffic.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rt_cnt_r <= RtWidth'(0);
      rt_r     <= 1'b0;
    end else if (rt_cnt_r == RtLast) begin
      rt_cnt_r <= RtWidth'(0);
      rt_r     <= ~rt_r;
    end else begin
      rt_cnt_r <= rt_cnt_r + RtWidth'(1);
      rt_r     <= rt_r;
    end
  end

  assign rt_clk_o = rt_r;

  for (genvar g = 0; g < NumPlls; g++) begin : g_ch
    logic [DivWidth-1:0]  div_r;
    logic [DivWidth-1:0]  pend_r;
    logic [DivWidth-1:0]  cnt_r;
    logic [LcntWidth-1:0] lcnt_r;
    logic                 out_r;
    logic                 dbg_r;
    logic                 lock_r;
    pll_state_e           state_r;
    logic                 term_s;
    logic                 exit_s;

    assign term_s = (div_r != DivWidth'(0)) && (cnt_r == (div_r - DivWidth'(1)));
    // Leave SWITCH only at the end of a high phase, or at once if parked low.
    assign exit_s = (state_r == ST_SWITCH) &&
                    ((out_r && term_s) || (!out_r && (div_r == DivWidth'(0))));
    assign sw_s[g]  = (state_r == ST_SWITCH);
    assign hit_s[g] = cfg_valid_i && (cfg_idx_i == IdxWidth'(g)) && (state_r != ST_SWITCH);

    // Channel divider, lock FSM and ratio-switch handshake.
    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        div_r   <= DivWidth'(DefaultDiv);
        pend_r  <= DivWidth'(DefaultDiv);
        cnt_r   <= DivWidth'(0);
        lcnt_r  <= LcntWidth'(0);
        out_r   <= 1'b0;
        dbg_r   <= 1'b0;
        lock_r  <= 1'b0;
        state_r <= ST_LOCKING;
      end else if (exit_s) begin
        out_r   <= 1'b0;
        div_r   <= pend_r;
        cnt_r   <= DivWidth'(0);
        lcnt_r  <= LcntWidth'(0);
        lock_r  <= 1'b0;
        state_r <= ST_LOCKING;
      end else begin
        // Divider keeps running at the current ratio, including during SWITCH.
        if (div_r == DivWidth'(0)) begin
          out_r <= 1'b0;
          cnt_r <= DivWidth'(0);
        end else if (term_s) begin
          out_r <= ~out_r;
          cnt_r <= DivWidth'(0);
          if (!out_r) begin
            dbg_r <= ~dbg_r;
          end else begin
            dbg_r <= dbg_r;
          end
        end else begin
          cnt_r <= cnt_r + DivWidth'(1);
        end

        if (hit_s[g]) begin
          pend_r  <= cfg_div_i;
          state_r <= ST_SWITCH;
          lock_r  <= 1'b0;
        end else begin
          case (state_r)
            ST_LOCKING: begin
              if (lcnt_r == LockLast) begin
                lcnt_r  <= LcntWidth'(0);
                state_r <= ST_LOCKED;
                lock_r  <= 1'b1;
              end else begin
                lcnt_r  <= lcnt_r + LcntWidth'(1);
                lock_r  <= 1'b0;
              end
            end
            ST_LOCKED: begin
              lock_r <= 1'b1;
            end
            ST_SWITCH: begin
              lock_r <= 1'b0;
            end
            default: begin
              state_r <= ST_LOCKING;
              lcnt_r  <= LcntWidth'(0);
              lock_r  <= 1'b0;
            end
          endcase
        end
      end
    end

    assign clk_pll_o[g] = out_r;
    assign dbg_pll_o[g] = dbg_r;
    assign lock_o[g]    = lock_r;
  end

endmodule

// File: tb/tb_clk_pll_emu.sv
module tb_clk_pll_emu;
  localparam int N  = 3;
  localparam int DW = 8;
  localparam int DEF = 1;
  localparam int LC = 16;
  localparam int RT = 16;
  localparam int IW = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cfg_valid = 1'b0;
  logic          cfg_ready;
  logic [IW-1:0] cfg_idx = '0;
  logic [DW-1:0] cfg_div = '0;
  logic          cfg_err;
  logic [N-1:0]  clk_pll;
  logic [N-1:0]  dbg_pll;
  logic [N-1:0]  lock;
  logic          rt_clk;

  clk_pll_emu #(
    .NumPlls(N), .DivWidth(DW), .DefaultDiv(DEF), .LockCycles(LC), .RtDiv(RT)
  ) dut (
    .clk_i(clk), .rst_i(rst), .cfg_valid_i(cfg_valid), .cfg_ready_o(cfg_ready),
    .cfg_idx_i(cfg_idx), .cfg_div_i(cfg_div), .cfg_err_o(cfg_err),
    .clk_pll_o(clk_pll), .dbg_pll_o(dbg_pll), .lock_o(lock), .rt_clk_o(rt_clk)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: each channel is a "segment" that started at edge seg[i]
  // with ratio mdiv[i]; levels follow from elapsed edges by plain arithmetic.
  int t;
  int seg[N];
  int mdiv[N];
  int pval[N];
  int xt[N];      // edge number at which a pending switch completes
  bit pon[N];
  bit dbg0[N];
  bit exp_err;
  bit last_acc;

  function automatic bit m_out(int i, int tt);
    if (mdiv[i] == 0) return 1'b0;
    return ((tt - seg[i]) / mdiv[i]) % 2 == 1;
  endfunction

  function automatic bit m_dbg(int i, int tt);
    int q;
    if (mdiv[i] == 0) return dbg0[i];
    q = (tt - seg[i]) / mdiv[i];
    return dbg0[i] ^ (((q + 1) / 2) % 2 == 1);
  endfunction

  function automatic bit m_lock(int i, int tt);
    return !pon[i] && ((tt - seg[i]) >= LC);
  endfunction

  task automatic model_reset();
    t = 0;
    exp_err = 1'b0;
    for (int i = 0; i < N; i++) begin
      seg[i] = 0; mdiv[i] = DEF; pval[i] = 0; xt[i] = 0; pon[i] = 1'b0; dbg0[i] = 1'b0;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s t=%0d observed=%0h expected=%0h", tag, t, obs, exp);
    end
  endtask

  task automatic check_outputs();
    logic [N-1:0] ec, ed, el;
    for (int i = 0; i < N; i++) begin
      ec[i] = m_out(i, t);
      ed[i] = m_dbg(i, t);
      el[i] = m_lock(i, t);
    end
    chk("clk_pll", 32'(clk_pll), 32'(ec));
    chk("dbg_pll", 32'(dbg_pll), 32'(ed));
    chk("lock",    32'(lock),    32'(el));
    chk("rt_clk",  32'(rt_clk),  32'((t / RT) % 2));
    chk("cfg_err", 32'(cfg_err), 32'(exp_err));
  endtask

  // One reference cycle: drive request, check ready, advance model, check outputs.
  task automatic cyc(input bit v, input int idx, input int d);
    bit acc;
    bit erdy;
    cfg_valid = v;
    cfg_idx   = idx[IW-1:0];
    cfg_div   = d[DW-1:0];
    #1;
    if (idx >= N) erdy = 1'b1;
    else          erdy = !pon[idx];
    chk("cfg_ready", 32'(cfg_ready), 32'(erdy));
    acc = v && erdy;
    @(posedge clk);
    t++;
    for (int i = 0; i < N; i++) begin
      if (pon[i] && xt[i] == t) begin
        dbg0[i] = m_dbg(i, t);
        seg[i]  = t;
        mdiv[i] = pval[i];
        pon[i]  = 1'b0;
      end
    end
    if (acc && idx < N) begin
      pon[idx]  = 1'b1;
      pval[idx] = d;
      if (mdiv[idx] == 0) xt[idx] = t + 1;
      else xt[idx] = seg[idx] + 2 * mdiv[idx] * ((t - seg[idx]) / (2 * mdiv[idx]) + 1);
    end
    exp_err  = acc && (idx >= N);
    last_acc = acc;
    #1;
    check_outputs();
  endtask

  // Hold a request until the DUT (per model) accepts it.
  task automatic send(input int idx, input int d);
    int k = 0;
    do begin
      cyc(1'b1, idx, d);
      k++;
    end while (!last_acc && k < 200);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cyc(1'b0, 0, 0);
  endtask

  // Asynchronous reset mid-cycle, then release just after an edge.
  task automatic do_reset();
    #3;
    rst = 1'b1;
    cfg_valid = 1'b0;
    #1;
    chk("rst_clk_pll", 32'(clk_pll), 32'd0);
    chk("rst_dbg_pll", 32'(dbg_pll), 32'd0);
    chk("rst_lock",    32'(lock),    32'd0);
    chk("rst_rt_clk",  32'(rt_clk),  32'd0);
    chk("rst_cfg_err", 32'(cfg_err), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    model_reset();
    @(posedge clk);
    #1;
    do_reset();

    // Defaults: period-2 clocks, lock after 16, rt period 32.
    idle(40);

    // ch1 -> D=3, requested while its output is low.
    if (m_out(1, t)) idle(1);
    cyc(1'b1, 1, 3);
    idle(50);

    // ch2 parked with D=0, then D=5.
    cyc(1'b1, 2, 0);
    send(2, 5);
    idle(60);

    // Back-to-back on ch0 with a ch1 request accepted in the same window.
    cyc(1'b1, 0, 2);
    cyc(1'b1, 1, 2);
    send(0, 4);
    idle(40);

    // Invalid index: error pulse only.
    cyc(1'b1, 3, 9);
    idle(4);

    // Reset while ch1 is mid-switch; pending ratio must be dropped.
    send(1, 7);
    cyc(1'b0, 0, 0);
    do_reset();
    idle(24);

    // Randomised traffic, including parked ratios and bad indices.
    for (int k = 0; k < 600; k++) begin
      cyc($urandom_range(0, 3) == 0, int'($urandom_range(0, 3)), int'($urandom_range(0, 6)));
    end
    do_reset();
    for (int k = 0; k < 300; k++) begin
      cyc($urandom_range(0, 1) == 0, int'($urandom_range(0, 3)), int'($urandom_range(0, 4)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
